piso_shift_out: RTL and testbench
=================================

Name: piso_shift_out

Overview:
- Parallel-in, serial-out reader for the Memory Elements family.
- Captures a WIDTH-bit word from a parallel register output via valid/ready handshake, then shifts it out one bit per clock with framing strobes.
- Sits between a parallel holding register and a serial consumer (deserializer or external pin).

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- D  input  WIDTH  parallel word to transmit.
- LOAD_VALID  input  1  D is valid; request a load.
- LOAD_READY  output  1  block can accept a word.
- SO  output  1  serial data bit.
- SO_VALID  output  1  SO carries a frame bit this cycle.
- SO_LAST  output  1  SO carries the final bit of the frame.
- BUSY  output  1  frame in progress.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N.
- Reset:
  - All outputs are registered.
  - RST_N low forces the following immediately, independent of CLK: state=IDLE, shift reg=0, bit counter=0, SO=0, SO_VALID=0, SO_LAST=0, BUSY=0.
  - LOAD_READY=0 while RST_N is low. It goes to 1 at the first CLK edge after RST_N deasserts.
- States: IDLE, SHIFT.
- IDLE:
  - LOAD_READY=1, SO_VALID=0, BUSY=0, SO=0.
  - Load occurs at a CLK edge where LOAD_VALID=1 and LOAD_READY=1. At that edge: D is captured into the shift reg, counter=0, state→SHIFT, LOAD_READY→0, BUSY→1.
  - The first bit is presented: SO=D[WIDTH-1] if MSB_FIRST=1, else D[0]. SO_VALID→1.
- SHIFT:
  - Each CLK edge advances one bit and increments the counter.
  - SO_LAST=1 exactly when the final frame bit is on SO.
  - On the edge after the final bit: state→IDLE, SO_VALID→0, SO_LAST→0, BUSY→0, LOAD_READY→1.
- Latency:
  - Load at edge k → bits valid during cycles k+1..k+WIDTH.
  - LOAD_READY returns high after edge k+WIDTH.
  - Minimum one-cycle gap between frames; no back-to-back loads.
- Boundary conditions:
  - D and LOAD_VALID are ignored while in SHIFT. Changing D mid-frame does not alter SO.
  - LOAD_VALID held high continuously: a new frame starts on every first IDLE edge.
  - Counter width is $clog2(WIDTH+1) and wraps to 0 on frame end. It never overruns.
  - RST_N asserted mid-frame aborts the frame; no partial SO_LAST is emitted.
  - RST_N deasserted in the same cycle as LOAD_VALID=1: no load. LOAD_READY is still 0 in that cycle.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - Frame length becomes WIDTH+1.
  - After the final data bit, one parity bit is sent: even parity, the XOR of all captured bits.
  - SO_LAST moves to the parity bit.
  - LOAD_READY returns after edge k+WIDTH+1.
- Undefined:
  - Frame is WIDTH bits, as above.
  - No parity logic is synthesized.

Test Plan:
- Reset: RST_N=0 at t=3ns mid-cycle → SO=0, SO_VALID=0, BUSY=0, LOAD_READY=0 immediately without a CLK edge. After release plus one edge → LOAD_READY=1.
- WIDTH=4, MSB_FIRST=1, D=4'b1111, LOAD_VALID pulse → SO=1,1,1,1 with SO_VALID=1 for 4 cycles. SO_LAST=1 on the 4th bit only. LOAD_READY=1 again in the 5th cycle.
- D=4'b0101, MSB_FIRST=1 → SO=0,1,0,1. Repeat with MSB_FIRST=0 → SO=1,0,1,0.
- Load D=4'b0101, then change D to 4'b1111 on cycle 2 → SO stream stays 0,1,0,1.
- Assert RST_N=0 during bit 2 of D=4'b1010 → outputs clear at once. After release, a fresh load of 4'b0011 → SO=0,0,1,1 cleanly.
- With PISO_PARITY_EN: D=4'b0111 → SO=0,1,1,1,1 (parity=1), SO_LAST on the 5th bit. D=4'b0101 → parity bit 0.

Source files
------------

// File: rtl/piso_shift_out.sv
// Parallel-in, serial-out reader: takes a WIDTH-bit word over a valid/ready handshake and shifts it out with framing strobes.
// Defining PISO_PARITY_EN appends one even-parity bit to every frame.
module piso_shift_out #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
    localparam logic [CW-1:0] PAR_IDX = CW'(WIDTH);
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

    // state | meaning
    // IDLE  | waiting for a handshake; SO quiet, ready asserted
    // SHIFT | frame bit cnt is on SO
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg, sreg_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             so_nx, so_valid_nx, so_last_nx, busy_nx, load_ready_nx;
`ifdef PISO_PARITY_EN
    logic             par, par_nx;
`endif

    always_comb begin
        state_nx      = state;
        sreg_nx       = sreg;
        cnt_nx        = cnt;
        so_nx         = so;
        so_valid_nx   = so_valid;
        so_last_nx    = so_last;
        busy_nx       = busy;
        load_ready_nx = load_ready;
`ifdef PISO_PARITY_EN
        par_nx        = par;
`endif
        case (state)
            IDLE: begin
                load_ready_nx = 1'b1;
                so_nx         = 1'b0;
                so_valid_nx   = 1'b0;
                so_last_nx    = 1'b0;
                busy_nx       = 1'b0;
                cnt_nx        = '0;
                // load_ready is still low on the first edge after reset, so no load there
                if (load_valid && load_ready) begin
                    state_nx      = SHIFT;
                    sreg_nx       = d;
                    so_nx         = MSB_FIRST ? d[WIDTH-1] : d[0];
                    so_valid_nx   = 1'b1;
                    busy_nx       = 1'b1;
                    load_ready_nx = 1'b0;
`ifdef PISO_PARITY_EN
                    par_nx        = ^d;
`endif
                end
            end
            SHIFT: begin
                if (cnt == LAST_IDX) begin
                    state_nx      = IDLE;
                    cnt_nx        = '0;
                    sreg_nx       = '0;
                    so_nx         = 1'b0;
                    so_valid_nx   = 1'b0;
                    so_last_nx    = 1'b0;
                    busy_nx       = 1'b0;
                    load_ready_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                    if (MSB_FIRST) begin
                        sreg_nx = {sreg[WIDTH-2:0], 1'b0};
                        so_nx   = sreg[WIDTH-2];
                    end else begin
                        sreg_nx = {1'b0, sreg[WIDTH-1:1]};
                        so_nx   = sreg[1];
                    end
`ifdef PISO_PARITY_EN
                    if (cnt_nx == PAR_IDX) so_nx = par;
`endif
                    so_last_nx = (cnt_nx == LAST_IDX);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            so         <= 1'b0;
            so_valid   <= 1'b0;
            so_last    <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b0;
`ifdef PISO_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            sreg       <= sreg_nx;
            cnt        <= cnt_nx;
            so         <= so_nx;
            so_valid   <= so_valid_nx;
            so_last    <= so_last_nx;
            busy       <= busy_nx;
            load_ready <= load_ready_nx;
`ifdef PISO_PARITY_EN
            par        <= par_nx;
`endif
        end
    end

endmodule

// File: tb/tb_piso_shift_out.sv
// Bench for piso_shift_out: MSB-first and LSB-first instances share stimulus and are checked against a bit-queue model.
// Honours PISO_PARITY_EN the same way the design does.
module tb_piso_shift_out;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] d;
    logic         load_valid;
    logic         rdy_m, so_m, vld_m, last_m, busy_m;
    logic         rdy_l, so_l, vld_l, last_l, busy_l;

    int n_vec = 0;
    int n_err = 0;

    logic q_m[$];
    logic q_l[$];
    logic rdy_exp;

    always #5 clk = ~clk;

    piso_shift_out #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .d(d), .load_valid(load_valid),
        .load_ready(rdy_m), .so(so_m), .so_valid(vld_m), .so_last(last_m), .busy(busy_m));

    piso_shift_out #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .d(d), .load_valid(load_valid),
        .load_ready(rdy_l), .so(so_l), .so_valid(vld_l), .so_last(last_l), .busy(busy_l));

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got {rdy,so,vld,last,busy}=%b expected %b", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [4:0] expv(input logic r, input int sz, input logic head);
        return {r, (sz > 0) ? head : 1'b0, sz > 0, sz == 1, sz > 0};
    endfunction

    task automatic model_reset();
        q_m.delete();
        q_l.delete();
        rdy_exp = 1'b0;
    endtask

    task automatic model_edge(input logic rv, input logic lv, input logic [W-1:0] dv);
        if (!rv) begin
            model_reset();
        end else if (q_m.size() > 0) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
            if (q_m.size() == 0) rdy_exp = 1'b1;
        end else if (rdy_exp && lv) begin
            for (int i = W - 1; i >= 0; i--) q_m.push_back(dv[i]);
            for (int i = 0; i < W; i++) q_l.push_back(dv[i]);
`ifdef PISO_PARITY_EN
            q_m.push_back(^dv);
            q_l.push_back(^dv);
`endif
            rdy_exp = 1'b0;
        end else begin
            rdy_exp = 1'b1;
        end
    endtask

    task automatic compare(input string tag);
        logic hm, hl;
        hm = (q_m.size() > 0) ? q_m[0] : 1'b0;
        hl = (q_l.size() > 0) ? q_l[0] : 1'b0;
        chk({tag, "_msb"}, {rdy_m, so_m, vld_m, last_m, busy_m}, expv(rdy_exp, q_m.size(), hm));
        chk({tag, "_lsb"}, {rdy_l, so_l, vld_l, last_l, busy_l}, expv(rdy_exp, q_l.size(), hl));
    endtask

    task automatic step(input string tag, input logic rv, input logic lv, input logic [W-1:0] dv);
        @(negedge clk);
        rst_n      = rv;
        load_valid = lv;
        d          = dv;
        @(posedge clk);
        #1;
        model_edge(rv, lv, dv);
        compare(tag);
    endtask

    // Drops reset between edges, checks the outputs clear without a clock, then releases with load_valid high.
    task automatic midcycle_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare({tag, "_async"});
        step({tag, "_hold"}, 1'b0, 1'b1, W'($urandom));
        step({tag, "_release"}, 1'b1, 1'b1, W'($urandom));
        step({tag, "_ready"}, 1'b1, 1'b0, W'($urandom));
    endtask

    initial begin
        rst_n      = 1'b1;
        load_valid = 1'b0;
        d          = '0;
        model_reset();
        #3 rst_n = 1'b0;
        #1 compare("reset_async");
        step("reset_hold", 1'b0, 1'b1, 4'hf);
        step("reset_release", 1'b1, 1'b1, 4'hf);
        step("ready_up", 1'b1, 1'b0, 4'h0);

        step("load_f", 1'b1, 1'b1, 4'hf);
        repeat (6) step("frame_f", 1'b1, 1'b0, 4'h0);

        step("load_5", 1'b1, 1'b1, 4'h5);
        step("frame_5", 1'b1, 1'b1, 4'hf);
        repeat (6) step("frame_5", 1'b1, 1'b1, 4'hf);

        step("load_a", 1'b1, 1'b1, 4'ha);
        step("frame_a", 1'b1, 1'b0, 4'h0);
        midcycle_reset("abort_a");
        step("load_3", 1'b1, 1'b1, 4'h3);
        repeat (6) step("frame_3", 1'b1, 1'b0, 4'h0);

        step("load_7", 1'b1, 1'b1, 4'h7);
        repeat (6) step("frame_7", 1'b1, 1'b0, 4'h0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0)
                midcycle_reset("rand_rst");
            else
                step("rand", 1'b1, $urandom_range(0, 3) != 0, W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
